// File: rtl/aes_iter_cipher.sv
// Iterative AES encryption engine: one cipher round per clock, NR selects AES-128/192/256.
// Round keys are fetched from an external key store through rk_idx/rk_data.
module aes_iter_cipher #(
  parameter int unsigned NR   = 10,
  parameter int unsigned IDXW = $clog2(NR + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_data,
  output logic [IDXW-1:0]  rk_idx,
  input  logic [127:0]     rk_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_data,
  output logic             busy
);

  localparam int unsigned BLKW = 128;
  localparam logic [IDXW-1:0] LAST_ROUND = IDXW'(NR);

  if (NR != 10 && NR != 12 && NR != 14) begin : g_bad_nr
    $error("aes_iter_cipher: NR must be 10, 12 or 14");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // GF(2^8) multiply-by-two with the AES reduction polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [BLKW-1:0] sub_bytes(input logic [BLKW-1:0] s);
    logic [BLKW-1:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      r[BLKW-1-8*i -: 8] = SBOX[s[BLKW-1-8*i -: 8]];
    end
    return r;
  endfunction

  // Byte (row, col) sits at index row + 4*col; row r rotates left by r columns.
  function automatic logic [BLKW-1:0] shift_rows(input logic [BLKW-1:0] s);
    logic [BLKW-1:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int w = 0; w < 4; w++) begin
        r[BLKW-1-8*(w+4*c) -: 8] = s[BLKW-1-8*(w+4*((c+w)%4)) -: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [BLKW-1:0] mix_columns(input logic [BLKW-1:0] s);
    logic [BLKW-1:0] r;
    logic [7:0] a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[BLKW-1-32*c -: 8];
      a1 = s[BLKW-9-32*c -: 8];
      a2 = s[BLKW-17-32*c -: 8];
      a3 = s[BLKW-25-32*c -: 8];
      r[BLKW-1-32*c  -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[BLKW-9-32*c  -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[BLKW-17-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[BLKW-25-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

  // One cipher round; the final round skips MixColumns.
  function automatic logic [BLKW-1:0] cipher_round(input logic [BLKW-1:0] s,
                                                   input logic [BLKW-1:0] k,
                                                   input logic            last);
    logic [BLKW-1:0] t;
    t = shift_rows(sub_bytes(s));
    return (last ? t : mix_columns(t)) ^ k;
  endfunction

  state_e            state_q, state_d;
  logic [IDXW-1:0]   round_q, round_d;
  logic [BLKW-1:0]   data_q, data_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;
  logic [IDXW-1:0]   rk_idx_q, rk_idx_d;
  logic              load;

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    data_d  = data_q;
    load    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        load = in_valid;
      end
      S_ROUND: begin
        data_d = cipher_round(data_q, rk_data, round_q == LAST_ROUND);
        if (round_q == LAST_ROUND) begin
          state_d = S_DONE;
          round_d = '0;
        end else begin
          round_d = round_q + IDXW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          load = in_valid;
          if (!in_valid) state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        round_d = '0;
      end
    endcase
    // Initial AddRoundKey; rk_idx is 0 in both IDLE and DONE so rk_data is key 0.
    if (load) begin
      data_d  = in_data ^ rk_data;
      round_d = IDXW'(1);
      state_d = S_ROUND;
    end
    out_valid_d = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
    rk_idx_d    = (state_d == S_ROUND) ? round_d : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      round_q     <= '0;
      data_q      <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      rk_idx_q    <= '0;
    end else begin
      state_q     <= state_d;
      round_q     <= round_d;
      data_q      <= data_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      rk_idx_q    <= rk_idx_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign rk_idx    = rk_idx_q;
  assign out_valid = out_valid_q;
  assign out_data  = data_q;
  assign busy      = busy_q;

endmodule
